vga_fb_scan: RTL and testbench

- Read-side engine for the 40x30 VGA framebuffer RAM.
- Generates 640x480@60 Hz timing from a 100 MHz system clock and walks the framebuffer read port, one 8-bit cell per 16x16 pixel block.
- Expands each 3-3-2 RGB byte to the Basys3 4-4-4 DAC pins.
- Sits between the framebuffer's read-only port (address out, data in) and the board VGA connector; the MCU keeps sole ownership of the write port.

---
 rtl/vga_fb_scan_pkg.sv | 37 +++
 rtl/vga_fb_scan_if.sv | 16 +
 rtl/vga_timing_gen.sv | 77 +++++++
 rtl/vga_fb_scan.sv | 78 +++++++
 tb/tb_vga_fb_scan.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/vga_fb_scan_pkg.sv
// Shared VGA timing constants, scan phase encoding and 3-3-2 to 4-4-4 pixel expansion.
package vga_pkg;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_H_VIS   = 640;
  localparam int DEF_H_FP    = 16;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BP    = 48;
  localparam int DEF_V_VIS   = 480;
  localparam int DEF_V_FP    = 10;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BP    = 33;
  localparam int H_TOTAL     = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL     = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {VISIBLE, FRONT, SYNC, BACK} h_phase_t;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Replicate MSBs so full-scale 3-bit/2-bit values reach full-scale 4-bit.
  function automatic rgb444_t rgb332_to_444(rgb332_t p);
    rgb444_t o;
    o.r = {p.r, p.r[2]};
    o.g = {p.g, p.g[2]};
    o.b = {p.b, p.b};
    return o;
  endfunction
endpackage

// File: rtl/vga_fb_scan_if.sv
// Framebuffer read port plus VGA connector pins, driven by the scan engine.
interface vga_fb_scan_if;
  logic [10:0] fb_addr;
  logic [7:0]  fb_data;
  logic        vga_hs;
  logic        vga_vs;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        frame_start;

  modport master (output fb_addr, vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start,
                  input  fb_data);
  modport slave  (input  fb_addr, vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start,
                  output fb_data);
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-clock divider, h/v scan counters, horizontal phase FSM and raw timing strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_VIS   = DEF_H_VIS,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_VIS   = DEF_V_VIS,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       tick_o,
  output logic [9:0] h_cnt_o,
  output logic [9:0] v_cnt_o,
  output logic       de_o,
  output logic       hs_n_o,
  output logic       vs_n_o,
  output logic       frame_start_o
);
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q;
  logic [9:0]    h_q, v_q;
  logic          fs_q;
  h_phase_t      ph_q, ph_d;
  logic          h_last, v_last;

  assign tick_o = (div_q == DW'(CLK_DIV - 1));
  assign h_last = (h_q == 10'(HT - 1));
  assign v_last = (v_q == 10'(VT - 1));

  // Phase tracks h_q; it advances on the tick that leaves the last pixel of a phase.
  always_comb begin
    ph_d = ph_q;
    case (ph_q)
      VISIBLE: if (h_q == 10'(H_VIS - 1))                 ph_d = FRONT;
      FRONT:   if (h_q == 10'(H_VIS + H_FP - 1))          ph_d = SYNC;
      SYNC:    if (h_q == 10'(H_VIS + H_FP + H_SYNC - 1)) ph_d = BACK;
      BACK:    if (h_last)                                ph_d = VISIBLE;
      default:                                            ph_d = VISIBLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      ph_q  <= VISIBLE;
      fs_q  <= 1'b0;
    end else begin
      fs_q <= tick_o & h_last & v_last;
      if (tick_o) begin
        div_q <= '0;
        ph_q  <= ph_d;
        h_q   <= h_last ? 10'd0 : h_q + 10'd1;
        if (h_last) v_q <= v_last ? 10'd0 : v_q + 10'd1;
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

  assign h_cnt_o       = h_q;
  assign v_cnt_o       = v_q;
  assign de_o          = (ph_q == VISIBLE) && (v_q < 10'(V_VIS));
  assign hs_n_o        = (ph_q != SYNC);
  assign vs_n_o        = !((v_q >= 10'(V_VIS + V_FP)) && (v_q < 10'(V_VIS + V_FP + V_SYNC)));
  assign frame_start_o = fs_q;
endmodule

// File: rtl/vga_fb_scan.sv
// Framebuffer scan-out: timing generator plus two-stage address/colour pipeline.
module vga_fb_scan
  import vga_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_VIS   = DEF_H_VIS,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_VIS   = DEF_V_VIS,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP
) (
  input  logic          CLK,
  input  logic          RST,
  vga_fb_scan_if.master bus
);
  logic       tick, de, hs_n, vs_n, fs;
  logic [9:0] h_cnt, v_cnt;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i        (CLK),
    .rst_i        (RST),
    .tick_o       (tick),
    .h_cnt_o      (h_cnt),
    .v_cnt_o      (v_cnt),
    .de_o         (de),
    .hs_n_o       (hs_n),
    .vs_n_o       (vs_n),
    .frame_start_o(fs)
  );

  // Low counter bits only select the pixel within a 16x16 cell.
  logic unused_cnt_bits;
  assign unused_cnt_bits = ^{h_cnt[3:0], v_cnt[9], v_cnt[3:0]};

  logic [10:0] addr_q, addr_d;
  logic        hs1_q, vs1_q, de1_q;
  logic        hs_q, vs_q;
  rgb444_t     rgb_q, rgb_d;

  always_comb begin
    addr_d = de ? {v_cnt[8:4], h_cnt[9:4]} : 11'd0;
    rgb_d  = de1_q ? rgb332_to_444(rgb332_t'(bus.fb_data)) : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q <= '0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      de1_q  <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      rgb_q  <= '0;
    end else if (tick) begin
      addr_q <= addr_d;
      hs1_q  <= hs_n;
      vs1_q  <= vs_n;
      de1_q  <= de;
      hs_q   <= hs1_q;
      vs_q   <= vs1_q;
      rgb_q  <= rgb_d;
    end
  end

  assign bus.fb_addr     = addr_q;
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_r       = rgb_q.r;
  assign bus.vga_g       = rgb_q.g;
  assign bus.vga_b       = rgb_q.b;
  assign bus.frame_start = fs;
endmodule

// File: tb/tb_vga_fb_scan.sv
// Directed bench: full-timing instance for line-level checks, shrunk instance for frame-level checks.
module tb_vga_fb_scan;
  logic CLK = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  always #5 CLK = ~CLK;

  int n_run  = 0;
  int n_fail = 0;

  vga_fb_scan_if if0 ();
  vga_fb_scan_if if1 ();

  logic [7:0] mem0 [0:2047];
  logic [7:0] mem1 [0:2047];
  assign if0.fb_data = mem0[if0.fb_addr];
  assign if1.fb_data = mem1[if1.fb_addr];

  vga_fb_scan u_dut0 (.CLK(CLK), .RST(rst0), .bus(if0));

  // 80x40 pixel frame: 320 CLKs per line, 12800 CLKs per frame.
  vga_fb_scan #(
    .CLK_DIV(4), .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(32), .V_FP(2), .V_SYNC(2), .V_BP(4)
  ) u_dut1 (.CLK(CLK), .RST(rst1), .bus(if1));

  int cyc0 = 0, cyc1 = 0, fs_cnt1 = 0;
  always @(posedge CLK) begin
    cyc0 <= rst0 ? 0 : cyc0 + 1;
    cyc1 <= rst1 ? 0 : cyc1 + 1;
    if (if1.frame_start) fs_cnt1 <= fs_cnt1 + 1;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int rgb0();
    return {if0.vga_r, if0.vga_g, if0.vga_b};
  endfunction
  function automatic int rgb1();
    return {if1.vga_r, if1.vga_g, if1.vga_b};
  endfunction

  task automatic wait_c0(input int n);
    while (cyc0 < n) begin @(posedge CLK); #1; end
  endtask
  task automatic wait_c1(input int n);
    while (cyc1 < n) begin @(posedge CLK); #1; end
  endtask

  // Returns cyc0 at which VGA_HS reaches lvl, or -1 on timeout.
  task automatic wait_hs0(input logic lvl, input int lim, output int at);
    at = -1;
    for (int k = 0; k < lim; k++) begin
      @(posedge CLK); #1;
      if (if0.vga_hs == lvl) begin at = cyc0; break; end
    end
  endtask

  int at, base;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem0[i] = i[7:0];
      mem1[i] = 8'hFF;
    end
    mem0[5] = 8'hE3;
    mem0[6] = 8'h1C;
    mem0[7] = 8'h49;

    // Full-timing instance: reset, address walk, colour mapping, line timing.
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_hs", if0.vga_hs, 1);
    chk("rst_vs", if0.vga_vs, 1);
    chk("rst_rgb", rgb0(), 0);
    chk("rst_addr", if0.fb_addr, 0);
    chk("rst_fs", if0.frame_start, 0);
    rst0 = 1'b0;

    wait_c0(64);   chk("addr_h15", if0.fb_addr, 0);
    wait_c0(68);   chk("addr_h16", if0.fb_addr, 1);
    wait_c0(200);  chk("rgb_03", rgb0(), 12'h00F);
    wait_c0(328);  chk("rgb_E3", rgb0(), 12'hF0F);
    wait_c0(392);  chk("rgb_1C", rgb0(), 12'h0F0);
    wait_c0(456);  chk("rgb_49", rgb0(), 12'h445);
    wait_c0(2560); chk("addr_h639", if0.fb_addr, 39);
    wait_c0(2564); chk("addr_h640", if0.fb_addr, 0);
    chk("rgb_h639", rgb0(), 12'h22F);
    wait_c0(2568); chk("rgb_hblank", rgb0(), 0);

    wait_hs0(1'b0, 4000, at); chk("hs_fall", at, 2632);
    wait_hs0(1'b1, 4000, at); chk("hs_rise", at, 3016);
    wait_c0(3268); chk("addr_line1", if0.fb_addr, 1);
    wait_hs0(1'b0, 4000, at); chk("hs_fall2", at, 5832);

    mem0[8] = 8'hE0;
    wait_c0(6920); chk("rgb_live_wr", rgb0(), 12'hF00);
    chk("vs_idle", if0.vga_vs, 1);

    // Shrunk instance: row stepping, blanking, vsync, frame pulse, mid-frame reset.
    @(posedge CLK); #1;
    rst1 = 1'b0;
    wait_c1(256);   chk("s_addr_h63", if1.fb_addr, 3);
    wait_c1(260);   chk("s_addr_h64", if1.fb_addr, 0);
    chk("s_rgb_h63", rgb1(), 12'hFFF);
    wait_c1(264);   chk("s_rgb_hblank", rgb1(), 0);
    wait_c1(276);   chk("s_hs_pre", if1.vga_hs, 1);
    wait_c1(280);   chk("s_hs_low", if1.vga_hs, 0);
    wait_c1(312);   chk("s_hs_post", if1.vga_hs, 1);
    wait_c1(5376);  chk("s_addr_r1c3", if1.fb_addr, 67);
    wait_c1(9924);  chk("s_addr_v31", if1.fb_addr, 64);
    wait_c1(9928);  chk("s_rgb_v31", rgb1(), 12'hFFF);
    wait_c1(10244); chk("s_addr_vblank", if1.fb_addr, 0);
    wait_c1(10248); chk("s_rgb_vblank", rgb1(), 0);
    wait_c1(10884); chk("s_vs_pre", if1.vga_vs, 1);
    wait_c1(10888); chk("s_vs_low", if1.vga_vs, 0);
    wait_c1(11528); chk("s_vs_post", if1.vga_vs, 1);
    wait_c1(12799); chk("s_fs_none", fs_cnt1, 0);
    chk("s_fs_pre", if1.frame_start, 0);
    wait_c1(12800); chk("s_fs_pulse", if1.frame_start, 1);
    wait_c1(12801); chk("s_fs_one", if1.frame_start, 0);
    wait_c1(25600); chk("s_fs_pulse2", if1.frame_start, 1);

    wait_c1(32010); chk("s_pre_rst_rgb", rgb1(), 12'hFFF);
    rst1 = 1'b1;
    @(posedge CLK); #1;
    chk("s_mrst_hs", if1.vga_hs, 1);
    chk("s_mrst_vs", if1.vga_vs, 1);
    chk("s_mrst_rgb", rgb1(), 0);
    chk("s_mrst_addr", if1.fb_addr, 0);
    base = fs_cnt1;
    rst1 = 1'b0;
    wait_c1(8);     chk("s_restart_rgb", rgb1(), 12'hFFF);
    wait_c1(68);    chk("s_restart_addr", if1.fb_addr, 1);
    wait_c1(12799); chk("s_restart_nofs", fs_cnt1, base);
    wait_c1(12800); chk("s_restart_fs", if1.frame_start, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
